// File: rtl/stack_machine_pkg.sv
// Shared definitions for the stack machine front-end.
// Holds the fetch-queue FSM state type and the default datapath width and reset PC.
package stack_machine_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    SQUASH = 2'd2
  } ifq_state_t;

  localparam int unsigned REG_BITS_DEFAULT = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/ifq_fifo.sv
// Storage for prefetched {instr, pc} entries with head/tail pointers and an occupancy count.
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   i_push, i_push_instr/pc      write one entry at the tail
//   i_pop                        drop the head entry (ignored while empty)
//   i_flush                      empty the queue (overrides push and pop)
//   o_count                      current occupancy, 0..DEPTH
//   o_valid, o_head_instr/pc     combinational head read; data reads as zero while empty
module ifq_fifo
  import stack_machine_pkg::*;
#(
  parameter int unsigned WIDTH = REG_BITS_DEFAULT,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_push_instr,
  input  logic [WIDTH-1:0]           i_push_pc,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_valid,
  output logic [WIDTH-1:0]           o_head_instr,
  output logic [WIDTH-1:0]           o_head_pc
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_instr_mem [DEPTH];
  logic [WIDTH-1:0] r_pc_mem    [DEPTH];
  logic [PtrW-1:0]  r_head;
  logic [PtrW-1:0]  r_tail;
  logic [CntW-1:0]  r_count;
  logic             w_do_pop;

  assign w_do_pop = i_pop && (r_count != '0);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push)   r_tail <= r_tail + 1'b1;
      if (w_do_pop) r_head <= r_head + 1'b1;
      r_count <= r_count + CntW'(i_push) - CntW'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !i_flush) begin
      r_instr_mem[r_tail] <= i_push_instr;
      r_pc_mem[r_tail]    <= i_push_pc;
    end
  end

  assign o_count      = r_count;
  assign o_valid      = (r_count != '0);
  assign o_head_instr = o_valid ? r_instr_mem[r_head] : '0;
  assign o_head_pc    = o_valid ? r_pc_mem[r_head]    : '0;

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch front-end: issues word-address fetches to a req/ack memory, buffers up
// to DEPTH {instr, pc} entries and presents the head to decode. A redirect flushes the queue
// and restarts fetch at redirect_pc; a fetch already in flight is completed and discarded.
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   mem_req/mem_addr             fetch request, held with a stable address until mem_ack
//   mem_ack/mem_rdata            fetch completion and returned instruction
//   instr_valid/instr/instr_pc   queue head towards decode
//   instr_ready                  decode consumes the head this cycle
//   redirect/redirect_pc         flush and restart fetch at a new PC
// Build option: define IFQ_BYPASS_EN to forward an ack straight to the outputs when the
// queue is empty (0-cycle fill latency); otherwise outputs come only from queue storage.
module instr_fetch_queue
  import stack_machine_pkg::*;
#(
  parameter int unsigned          REG_BITS = REG_BITS_DEFAULT,
  parameter int unsigned          DEPTH    = 4,
  parameter logic [REG_BITS-1:0]  RESET_PC = RESET_PC_DEFAULT[REG_BITS-1:0]
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                mem_req,
  output logic [REG_BITS-1:0] mem_addr,
  input  logic                mem_ack,
  input  logic [REG_BITS-1:0] mem_rdata,
  output logic                instr_valid,
  output logic [REG_BITS-1:0] instr,
  output logic [REG_BITS-1:0] instr_pc,
  input  logic                instr_ready,
  input  logic                redirect,
  input  logic [REG_BITS-1:0] redirect_pc
);

  localparam int unsigned CntW = $clog2(DEPTH+1);

  ifq_state_t          r_state;
  logic [REG_BITS-1:0] r_fetch_pc;
  logic [REG_BITS-1:0] r_req_addr;
  logic                r_mem_req;

  logic [CntW-1:0]     w_count;
  logic [CntW-1:0]     w_count_next;
  logic                w_fifo_valid;
  logic [REG_BITS-1:0] w_fifo_instr;
  logic [REG_BITS-1:0] w_fifo_pc;
  logic                w_ack_live;
  logic                w_bypass;
  logic                w_push;
  logic                w_pop;
  logic                w_room;
  logic                w_issue;

  // An ack only delivers data for a live (non-squashed) request with no redirect this cycle.
  assign w_ack_live = (r_state == REQ) && mem_ack && !redirect;

`ifdef IFQ_BYPASS_EN
  assign w_bypass = w_ack_live && (w_count == '0);
`else
  assign w_bypass = 1'b0;
`endif

  assign instr_valid = w_fifo_valid || w_bypass;
  assign instr       = w_bypass ? mem_rdata  : w_fifo_instr;
  assign instr_pc    = w_bypass ? r_req_addr : w_fifo_pc;

  // A bypassed entry consumed in the same cycle never enters storage.
  assign w_push       = w_ack_live && !(w_bypass && instr_ready);
  assign w_pop        = w_fifo_valid && instr_ready && !redirect;
  assign w_count_next = w_count + CntW'(w_push) - CntW'(w_pop);
  // Issue only when a slot is reserved for the returning data, so the queue cannot overflow.
  assign w_room       = w_count_next < CntW'(DEPTH);
  assign w_issue      = !redirect && w_room &&
                        ((r_state == IDLE) || ((r_state == REQ) && mem_ack));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_fetch_pc <= RESET_PC;
      r_req_addr <= RESET_PC;
      r_mem_req  <= 1'b0;
    end else begin
      if (redirect) begin
        r_fetch_pc <= redirect_pc;
      end else if (w_issue) begin
        r_fetch_pc <= r_fetch_pc + 1'b1;
        r_req_addr <= r_fetch_pc;
      end
      case (r_state)
        IDLE: begin
          if (w_issue) begin
            r_state   <= REQ;
            r_mem_req <= 1'b1;
          end
        end
        REQ: begin
          if (mem_ack) begin
            if (!w_issue) begin
              r_state   <= IDLE;
              r_mem_req <= 1'b0;
            end
          end else if (redirect) begin
            // The request stays on the bus until acked; its data will be dropped.
            r_state <= SQUASH;
          end
        end
        SQUASH: begin
          if (mem_ack) begin
            r_state   <= IDLE;
            r_mem_req <= 1'b0;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req  = r_mem_req;
  assign mem_addr = r_req_addr;

  ifq_fifo #(
    .WIDTH (REG_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_push       (w_push),
    .i_push_instr (mem_rdata),
    .i_push_pc    (r_req_addr),
    .i_pop        (w_pop),
    .i_flush      (redirect),
    .o_count      (w_count),
    .o_valid      (w_fifo_valid),
    .o_head_instr (w_fifo_instr),
    .o_head_pc    (w_fifo_pc)
  );

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed phases against a queue-level model of the fetch
// front-end, with a latency-programmable memory responder and hand-computed spot checks.
module tb_instr_fetch_queue;

  localparam int unsigned REG_BITS = 32;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RST_PC   = 32'h0000_0010;
`ifdef IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          lat = 0;
  int          wait_cnt = 0;
  logic [31:0] hs[$];
  bit          saw20 = 1'b0;

  // Model: pending PCs in order, plus the one outstanding request (0 none, 1 live, 2 dropped).
  logic [31:0] m_q[$];
  int          m_kind = 0;
  logic [31:0] m_addr = RST_PC;
  logic [31:0] m_pc = RST_PC;

  instr_fetch_queue #(
    .REG_BITS (REG_BITS),
    .DEPTH    (DEPTH),
    .RESET_PC (RST_PC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_5A5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_valid_now();
    return (m_q.size() > 0) || (BYP && m_kind == 1 && mem_ack && !redirect);
  endfunction

  // Model update at each edge from the inputs presented during the cycle.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_q.delete();
      m_kind = 0;
      m_addr = RST_PC;
      m_pc   = RST_PC;
    end else begin
      bit vnow;
      bit can_issue;
      vnow = m_valid_now();
      if (redirect) begin
        m_q.delete();
        m_pc = redirect_pc;
        if (m_kind == 1)                  m_kind = mem_ack ? 0 : 2;
        else if (m_kind == 2 && mem_ack)  m_kind = 0;
      end else begin
        can_issue = (m_kind == 0);
        if (m_kind == 2 && mem_ack) begin
          m_kind = 0;
        end else if (m_kind == 1 && mem_ack) begin
          m_q.push_back(m_addr);
          m_kind    = 0;
          can_issue = 1'b1;
        end
        if (vnow && instr_ready) void'(m_q.pop_front());
        if (can_issue && m_q.size() < DEPTH) begin
          m_kind = 1;
          m_addr = m_pc;
          m_pc   = m_pc + 32'd1;
        end
      end
    end
  end

  // Compare process: every falling edge.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_mem_addr", mem_addr, RST_PC);
      chk("rst_instr_valid", 32'(instr_valid), 32'd0);
      chk("rst_instr", instr, 32'd0);
      chk("rst_instr_pc", instr_pc, 32'd0);
    end else begin
      bit          ev;
      logic [31:0] epc;
      ev  = m_valid_now();
      epc = (m_q.size() > 0) ? m_q[0] : m_addr;
      chk("mem_req", 32'(mem_req), 32'(m_kind != 0));
      if (m_kind != 0) chk("mem_addr", mem_addr, m_addr);
      chk("instr_valid", 32'(instr_valid), 32'(ev));
      if (ev) begin
        chk("instr_pc", instr_pc, epc);
        chk("instr", instr, memfn(epc));
      end
    end
  end

  // One cycle: wait for the edge, then answer the memory request for the new cycle.
  task automatic cyc();
    @(posedge clk);
    #2;
    if (mem_req) begin
      if (wait_cnt >= lat) begin
        mem_ack  = 1'b1;
        wait_cnt = 0;
      end else begin
        mem_ack  = 1'b0;
        wait_cnt++;
      end
    end else begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end
    mem_rdata = memfn(mem_addr);
    if (mem_req && mem_ack) hs.push_back(mem_addr);
    if (instr_valid && instr_pc == 32'h20) saw20 = 1'b1;
  endtask

  // Zero-wait memory, no consumption: ends idle with a full queue.
  task automatic settle();
    lat         = 0;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    repeat (8) cyc();
  endtask

  initial begin
    // Reset, then stream from RESET_PC.
    instr_ready = 1'b1;
    repeat (3) cyc();
    #1;
    chk("reset_mem_req", 32'(mem_req), 32'd0);
    chk("reset_mem_addr", mem_addr, 32'h10);
    chk("reset_instr_valid", 32'(instr_valid), 32'd0);
    rst_n = 1'b1;
    cyc();
    #1;
    chk("c1_mem_req", 32'(mem_req), 32'd1);
    chk("c1_mem_addr", mem_addr, 32'h10);
    chk("c1_instr_valid", 32'(instr_valid), 32'(BYP));
    cyc();
    #1;
    chk("c2_mem_addr", mem_addr, 32'h11);
    chk("c2_instr_pc", instr_pc, BYP ? 32'h11 : 32'h10);
    chk("c2_instr", instr, memfn(BYP ? 32'h11 : 32'h10));
    repeat (6) cyc();

    // Stall: exactly DEPTH requests, then one more per freed slot.
    instr_ready = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h0;
    cyc();
    redirect = 1'b0;
    hs.delete();
    repeat (8) cyc();
    chk("stall_req_count", 32'(hs.size()), 32'd4);
    for (int i = 0; i < 4; i++) if (i < hs.size()) chk("stall_req_addr", hs[i], 32'(i));
    chk("stall_mem_req", 32'(mem_req), 32'd0);
    hs.delete();
    instr_ready = 1'b1;
    cyc();
    instr_ready = 1'b0;
    repeat (6) cyc();
    chk("refill_req_count", 32'(hs.size()), 32'd1);
    if (hs.size() > 0) chk("refill_req_addr", hs[0], 32'h4);
    chk("refill_mem_req", 32'(mem_req), 32'd0);

    // Redirect during a slow fetch: the pending request completes and is dropped.
    lat         = 3;
    instr_ready = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h20;
    cyc();
    redirect = 1'b0;
    hs.delete();
    saw20 = 1'b0;
    cyc();
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    cyc();
    redirect = 1'b0;
    #1;
    chk("squash_mem_req", 32'(mem_req), 32'd1);
    chk("squash_mem_addr", mem_addr, 32'h20);
    cyc();
    cyc();
    #1;
    chk("squash_ack_addr", mem_addr, 32'h20);
    repeat (10) cyc();
    chk("squash_hs_count_min", 32'(hs.size() >= 2), 32'd1);
    if (hs.size() > 1) begin
      chk("squash_old_addr", hs[0], 32'h20);
      chk("squash_next_addr", hs[1], 32'h40);
    end
    chk("squash_data_hidden", 32'(saw20), 32'd0);

    // Redirect coinciding with ack and ready while two entries are queued.
    settle();
    redirect    = 1'b1;
    redirect_pc = 32'h80;
    cyc();
    redirect = 1'b0;
    repeat (3) cyc();
    #1;
    chk("pre_redir_valid", 32'(instr_valid), 32'd1);
    chk("pre_redir_pc", instr_pc, 32'h80);
    chk("pre_redir_ack", 32'(mem_ack), 32'd1);
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    instr_ready = 1'b1;
    cyc();
    redirect = 1'b0;
    #1;
    chk("post_redir_valid", 32'(instr_valid), 32'd0);
    chk("post_redir_req", 32'(mem_req), 32'd0);
    cyc();
    #1;
    chk("post_redir_req2", 32'(mem_req), 32'd1);
    chk("post_redir_addr", mem_addr, 32'h100);
    repeat (4) cyc();

    // Address wrap.
    settle();
    instr_ready = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    cyc();
    redirect = 1'b0;
    hs.delete();
    repeat (4) cyc();
    chk("wrap_hs_count_min", 32'(hs.size() >= 2), 32'd1);
    if (hs.size() > 1) begin
      chk("wrap_addr_max", hs[0], 32'hFFFF_FFFF);
      chk("wrap_addr_zero", hs[1], 32'h0);
    end

    // Asynchronous reset mid-request with three entries queued.
    settle();
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    cyc();
    redirect = 1'b0;
    repeat (4) cyc();
    #1;
    chk("pre_rst_req", 32'(mem_req), 32'd1);
    chk("pre_rst_addr", mem_addr, 32'h203);
    rst_n = 1'b0;
    #1;
    chk("async_rst_req", 32'(mem_req), 32'd0);
    chk("async_rst_addr", mem_addr, 32'h10);
    chk("async_rst_valid", 32'(instr_valid), 32'd0);
    chk("async_rst_instr", instr, 32'd0);
    chk("async_rst_pc", instr_pc, 32'd0);
    instr_ready = 1'b1;
    cyc();
    rst_n = 1'b1;
    cyc();
    #1;
    chk("rerun_req", 32'(mem_req), 32'd1);
    chk("rerun_addr", mem_addr, 32'h10);
    chk("rerun_valid", 32'(instr_valid), 32'(BYP));
    if (BYP) chk("rerun_bypass_pc", instr_pc, 32'h10);
    cyc();
    #1;
    chk("rerun_valid2", 32'(instr_valid), 32'd1);
    chk("rerun_pc2", instr_pc, BYP ? 32'h11 : 32'h10);
    repeat (4) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Instruction fetch front-end for the single-cycle stack machine. Sits between a variable-latency instruction memory (req/ack) and the decode/control stage. Keeps up to DEPTH prefetched instructions with their PCs. On a branch or return it flushes the queue and restarts at the redirect target, discarding any in-flight fetch.

## Interface
- REG_BITS, 32: instruction, PC and address width (16 or 32).
- DEPTH, 4: queue entries, power of two, 2..16.
- RESET_PC, 0: first fetch address after reset.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- mem_req  out  1  fetch request; held high until mem_ack.
- mem_addr  out  REG_BITS  fetch word address; stable while mem_req=1.
- mem_ack  in  1  request complete this cycle; mem_rdata is valid.
- mem_rdata  in  REG_BITS  fetched instruction.
- instr_valid  out  1  queue head is valid.
- instr  out  REG_BITS  head instruction.
- instr_pc  out  REG_BITS  address of the head instruction.
- instr_ready  in  1  core consumes the head this cycle (pop when instr_valid=1).
- redirect  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  REG_BITS  new fetch address.

## Operation
- PCs are word addresses. Sequential fetch adds 1 modulo 2^REG_BITS, so all-ones wraps to 0.
- Registers: fetch_pc (next address to issue), req_addr (drives mem_addr), count (0..DEPTH), head/tail pointers, FSM state.
- count_next = count + push - pop. A pop happens when instr_valid && instr_ready && !redirect.
- FSM:
  - IDLE: mem_req=0. If !redirect and count_next<DEPTH: req_addr<=fetch_pc, fetch_pc+=1, go to REQ.
  - REQ: mem_req=1.
    - On mem_ack with no redirect: push {mem_rdata, req_addr}. If count_next<DEPTH, issue the next address back-to-back and stay in REQ; otherwise go to IDLE.
    - On redirect without ack: go to SQUASH.
    - On redirect with ack: drop the data and go to IDLE.
  - SQUASH: mem_req=1, the request is still pending. On mem_ack, drop the data and go to IDLE. A redirect here only updates fetch_pc.
- Redirect, in any state: count<=0, pointers<=0, fetch_pc<=redirect_pc. No pop or push that cycle.
- At most one request is outstanding. A request is never withdrawn once mem_req=1, even after a squash.
- No overflow is possible: a request is issued only when a slot is reserved for its data.
- Pop while empty is ignored.

## Timing
- Reset values: mem_req=0, mem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0. fetch_pc=RESET_PC, state IDLE, count=0.
- The first rising edge after rst_n deasserts moves the FSM to REQ, so mem_req=1 in cycle 1 with mem_addr=RESET_PC.
- Ack at edge k means instr_valid=1 after edge k (1-cycle fill latency when no bypass).
- A zero-wait memory (ack every cycle) with instr_ready=1 sustains one instruction per cycle.
- rst_n asserted mid-request returns the block to its reset values immediately. The memory must tolerate the dropped request.
- Redirect takes effect at the next edge. The new-target request is visible one cycle after leaving REQ/SQUASH for IDLE.

## Configuration
- IFQ_BYPASS_EN defined:
  - When count=0, state=REQ, mem_ack=1 and !redirect, the block drives instr_valid=1, instr=mem_rdata and instr_pc=req_addr combinationally in the same cycle.
  - If instr_ready=1 that cycle, the entry is not pushed. Otherwise it is pushed as normal.
  - Fill latency is 0 cycles.
- IFQ_BYPASS_EN undefined: outputs come only from queue registers, and fill latency is 1 cycle.

## Structure
- Shared package stack_machine_pkg holds:
  - ifq_state_t (IDLE, REQ, SQUASH)
  - the default REG_BITS constant
  - the RESET_PC default
- One sub-module, ifq_fifo: a storage array of {instr, pc} entries with head/tail/count, push, pop, flush and a combinational head read.
- The FSM and fetch_pc logic live in instr_fetch_queue.

## Test plan
- Reset release with RESET_PC=0x10 and ack every cycle, instr_ready=1: mem_addr sequence 0x10, 0x11, 0x12…; instr_pc follows one cycle behind; instr matches the memory model.
- instr_ready=0, DEPTH=4, ack every cycle: exactly 4 requests (0..3), then mem_req=0 and count=4. Raising instr_ready for one cycle triggers exactly one new request, for address 4.
- Ack delayed 3 cycles, redirect to 0x40 in cycle 1 of the wait: mem_req stays high at the old address until the ack, that data is never delivered, and the next request is for 0x40.
- Redirect in the same cycle as mem_ack and instr_ready with count=2: nothing is pushed or popped, instr_valid=0 next cycle, and the next request is for redirect_pc.
- fetch_pc=0xFFFFFFFF (REG_BITS=32): the following request is for address 0.
- rst_n pulsed low while in REQ with count=3: outputs go to reset values asynchronously, and after release the fetch restarts at RESET_PC. With IFQ_BYPASS_EN, the first instruction appears in the same cycle as its ack.
